// File: rtl/seq_mult_42x17_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_42x17_pkg
//  Description : Shared widths and FSM encoding for the 42x17 sequential
//                shift-and-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_42x17_pkg;

   localparam int MCAND_W  = 42;
   localparam int MPLIER_W = 17;
   localparam int PROD_W   = MCAND_W + MPLIER_W;
   // Iteration counter must hold MPLIER_W-1 = 16
   localparam int CNT_W    = 5;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_step
//  Description : One radix-2 shift-and-add iteration. Conditionally adds the
//                multiplicand into the upper accumulator half (carry kept) and
//                shifts the whole accumulator right by one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_step #(
   parameter int MCAND_W  = seq_mult_42x17_pkg::MCAND_W,
   parameter int MPLIER_W = seq_mult_42x17_pkg::MPLIER_W
) (
   input  logic [MCAND_W+MPLIER_W-1:0] i_acc,
   input  logic [MCAND_W-1:0]          i_mcand,
   output logic [MCAND_W+MPLIER_W-1:0] o_acc_next
);

   localparam int PROD_W = MCAND_W + MPLIER_W;

   logic [MCAND_W-1:0] w_addend;
   logic [MCAND_W:0]   w_sum;

   // Add when the current multiplier LSB is set; the 43rd bit catches the carry
   // and is shifted into the top of the accumulator so it is never lost.
   always_comb begin
      w_addend   = i_acc[0] ? i_mcand : '0;
      w_sum      = {1'b0, i_acc[PROD_W-1:MPLIER_W]} + {1'b0, w_addend};
      o_acc_next = {w_sum, i_acc[MPLIER_W-1:1]};
   end

endmodule
`default_nettype wire

// File: rtl/seq_mult_42x17.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_42x17
//  Description : Sequential unsigned multiplier, 42-bit x 17-bit -> 59-bit,
//                one multiplier bit per clock, valid/ready on both sides.
//                Drives the A operand of the downstream accumulate adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_42x17 #(
   parameter int MCAND_W  = seq_mult_42x17_pkg::MCAND_W,
   parameter int MPLIER_W = seq_mult_42x17_pkg::MPLIER_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [MCAND_W-1:0]           mcand,
   input  logic [MPLIER_W-1:0]          mplier,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [MCAND_W+MPLIER_W-1:0]  product,
   output logic                         busy
);

   import seq_mult_42x17_pkg::*;

   // Derived from the operand widths; intentionally not a parameter
   localparam int PROD_W = MCAND_W + MPLIER_W;

   state_t              r_state;
   state_t              w_state_next;
   logic [PROD_W-1:0]   r_acc;
   logic [MCAND_W-1:0]  r_mcand;
   logic [CNT_W-1:0]    r_cnt;
   logic [PROD_W-1:0]   w_acc_step;
   logic                w_accept;
   logic                w_last;

   assign w_accept = in_valid && (r_state == IDLE);
   assign w_last   = (r_cnt == CNT_W'(MPLIER_W - 1));

   seq_mult_step #(
      .MCAND_W  (MCAND_W),
      .MPLIER_W (MPLIER_W)
   ) u_step (
      .i_acc      (r_acc),
      .i_mcand    (r_mcand),
      .o_acc_next (w_acc_step)
   );

   // State register; reset aborts any computation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode: accept in IDLE, 17 iterations in RUN, hold in DONE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_next = RUN;
         RUN:     if (w_last)    w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Operand latch, accumulator iteration and iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mcand <= mcand;
                  r_acc   <= {{MCAND_W{1'b0}}, mplier};
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_acc <= w_acc_step;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            default: begin
               r_acc <= r_acc;
            end
         endcase
      end
   end

   // Handshake outputs come from the state register only; the product is
   // gated so partial sums never appear outside DONE.
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      busy      = (r_state == RUN) || (r_state == DONE);
      product   = (r_state == DONE) ? r_acc : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_42x17.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_42x17
//  Description : Self-checking bench for seq_mult_42x17. Directed cases plus
//                randomized back-to-back traffic scored against a plain
//                a*b reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_42x17;

   localparam int MCAND_W  = 42;
   localparam int MPLIER_W = 17;
   localparam int PROD_W   = MCAND_W + MPLIER_W;
   localparam int N_RAND   = 1000;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [MCAND_W-1:0]   mcand;
   logic [MPLIER_W-1:0]  mplier;
   logic                 out_valid;
   logic                 out_ready;
   logic [PROD_W-1:0]    product;
   logic                 busy;

   int n_checks = 0;
   int n_errors = 0;

   seq_mult_42x17 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mcand     (mcand),
      .mplier    (mplier),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain unsigned multiplication in 64 bits
   function automatic logic [63:0] ref_mul(input logic [MCAND_W-1:0] a, input logic [MPLIER_W-1:0] b);
      logic [63:0] wa, wb;
      wa = 64'(a);
      wb = 64'(b);
      return wa * wb;
   endfunction

   function automatic logic [MCAND_W-1:0] rand_mcand();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[MCAND_W-1:0];
   endfunction

   function automatic logic [MPLIER_W-1:0] rand_mplier();
      logic [31:0] t;
      t = $urandom();
      return t[MPLIER_W-1:0];
   endfunction

   // One full transaction: accept, latency, product, optional backpressure, return to IDLE
   task automatic do_op(input logic [MCAND_W-1:0] a, input logic [MPLIER_W-1:0] b,
                        input logic [63:0] exp, input int hold, input string tag);
      int  n;
      bit  seen;
      logic [PROD_W-1:0] held;
      @(posedge clk); #2;
      mcand     = a;
      mplier    = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      seen = 0;
      n    = 0;
      while (!seen && n < 50) begin
         @(negedge clk);
         if (in_ready) seen = 1;
         n++;
      end
      check_val({tag, "_accept"}, 64'(seen), 64'd1);
      // Source keeps valid high but churns operands; the latched copy must be used
      @(posedge clk); #2;
      mcand  = rand_mcand();
      mplier = rand_mplier();
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 5) begin
            check_val({tag, "_run_inready"}, 64'(in_ready), 64'd0);
            check_val({tag, "_run_busy"}, 64'(busy), 64'd1);
         end
      end while (!out_valid && n < 60);
      in_valid = 1'b0;
      check_val({tag, "_latency"}, 64'(n), 64'd18);
      check_val({tag, "_product"}, 64'(product), exp);
      check_val({tag, "_done_inready"}, 64'(in_ready), 64'd0);
      check_val({tag, "_done_busy"}, 64'(busy), 64'd1);
      if (hold > 0) begin
         held = product;
         repeat (hold) begin
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check_val({tag, "_hold_product"}, 64'(product), 64'(held));
            check_val({tag, "_hold_inready"}, 64'(in_ready), 64'd0);
         end
         @(posedge clk); #2;
         out_ready = 1'b1;
         @(negedge clk);
         check_val({tag, "_release_valid"}, 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      check_val({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
      check_val({tag, "_idle_inready"}, 64'(in_ready), 64'd1);
      check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin : main
      logic [63:0] exp_q[$];
      int   cyc, last_acc, accepts, dones, stale, n;
      bit   seen;

      // Reset with random inputs applied
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      mcand     = rand_mcand();
      mplier    = rand_mplier();
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check_val("rst_inready", 64'(in_ready), 64'd1);
      check_val("rst_outvalid", 64'(out_valid), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_product", 64'(product), 64'd0);
      repeat (3) @(posedge clk);
      #2;
      check_val("rst_held_busy", 64'(busy), 64'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      // Directed cases
      do_op(42'd3, 17'd5, 64'd15, 0, "basic");
      do_op(42'h3FFFFFFFFFF, 17'h1FFFF, 64'h07FFFBFFFFFE0001, 0, "max");
      do_op(42'h2AAAAAAAAAA, 17'h10000, 64'h02AAAAAAAAAA0000, 10, "bp");
      do_op(42'd0, 17'h1FFFF, 64'd0, 0, "zero_mcand");
      do_op(42'h3FFFFFFFFFF, 17'd0, 64'd0, 0, "zero_mplier");

      // Reset in the middle of RUN
      @(posedge clk); #2;
      mcand     = rand_mcand();
      mplier    = rand_mplier();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      n    = 0;
      while (!seen && n < 50) begin
         @(negedge clk);
         if (in_ready) seen = 1;
         n++;
      end
      check_val("midrst_accept", 64'(seen), 64'd1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("midrst_inready", 64'(in_ready), 64'd1);
      check_val("midrst_outvalid", 64'(out_valid), 64'd0);
      check_val("midrst_busy", 64'(busy), 64'd0);
      check_val("midrst_product", 64'(product), 64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      stale = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check_val("midrst_stale_valid", 64'(stale), 64'd0);
      do_op(42'd7, 17'd9, 64'd63, 0, "post_rst");

      // Back-to-back random traffic: valid always high, operands change every cycle
      cyc      = 0;
      last_acc = -1;
      accepts  = 0;
      dones    = 0;
      @(posedge clk); #2;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      mcand     = rand_mcand();
      mplier    = rand_mplier();
      while (dones < N_RAND && cyc < 40000) begin
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_mul(mcand, mplier));
            if (last_acc >= 0 && accepts < 20)
               check_val("b2b_spacing", 64'(cyc - last_acc), 64'd19);
            last_acc = cyc;
            accepts++;
         end
         if (out_valid) begin
            check_val("b2b_done_inready", 64'(in_ready), 64'd0);
            if (out_ready) begin
               if (exp_q.size() == 0)
                  check_val("b2b_spurious", 64'd1, 64'd0);
               else
                  check_val("b2b_product", 64'(product), exp_q.pop_front());
               dones++;
            end
         end
         cyc++;
         @(posedge clk); #2;
         mcand     = rand_mcand();
         mplier    = rand_mplier();
         out_ready = (accepts < 20) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      end
      check_val("b2b_completed", 64'(dones), 64'(N_RAND));
      in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
